// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper_pkg
//  Description : Shared types and constants for the truth-table sweeper.
//  Revision    : 1.0 - initial release
// ============================================================================
package truth_table_sweeper_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    // Default geometry: four circuit inputs, four settle cycles per vector
    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 4;

    // Width of the settle timer; bounds SETTLE_CYCLES to 1..255
    localparam int TIMER_W = 8;

    // Golden truth table of lab circuit 2: out = ~(((A&B)|~C)&D)
    localparam logic [15:0] LAB2_GOLDEN = 16'h70FF;

endpackage : truth_table_sweeper_pkg
`default_nettype wire

// File: rtl/sweep_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_settle_timer
//  Description : Load/decrement counter that times how long each vector is
//                held before sampling. zero is high once the count runs out.
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    // A zero settle time is meaningless and larger values overflow the timer
    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..255");
    end

    // Load SETTLE_CYCLES-1 so that, together with the SAMPLE cycle, each
    // vector is held for SETTLE_CYCLES+1 clocks
    localparam logic [TIMER_W-1:0] c_RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

    logic [TIMER_W-1:0] r_count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : sweep_settle_timer
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Steps a small combinational circuit through every input
//                vector, samples its output after a settle time, builds the
//                measured truth table and compares it to a latched golden one.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   result,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_count
);

    localparam int c_VECTORS = 1 << N_IN;

    sweep_state_t           r_state;
    logic [N_IN-1:0]        r_idx;
    logic [c_VECTORS-1:0]   r_exp;
    logic [c_VECTORS-1:0]   r_result;
    logic [N_IN:0]          r_mm;
    logic                   r_pass;
    logic                   r_done;
    logic                   r_busy;

    logic                   w_timer_load;
    logic                   w_timer_zero;
    logic                   w_last;
    logic                   w_mismatch;
    logic [N_IN:0]          w_mm_next;

    // Timer reload points, last-vector detect and running mismatch total
    always_comb begin
        w_last       = (r_idx == {N_IN{1'b1}});
        w_timer_load = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_SAMPLE) && !w_last);
        w_mismatch   = dut_out ^ r_exp[r_idx];
        w_mm_next    = r_mm + (N_IN+1)'(w_mismatch);
    end

    sweep_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_timer_load),
        .zero  (w_timer_zero)
    );

    // Sweep sequencer: all outputs registered; the index doubles as dut_in
    // so the applied vector only moves on the start edge or leaving SAMPLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_exp    <= '0;
            r_result <= '0;
            r_mm     <= '0;
            r_pass   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_SETTLE;
                        r_idx    <= '0;
                        r_exp    <= expected;
                        r_result <= '0;
                        r_mm     <= '0;
                        r_pass   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_timer_zero) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_result[r_idx] <= dut_out;
                    r_mm            <= w_mm_next;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mm_next == '0);
                    end else begin
                        r_idx   <= r_idx + N_IN'(1);
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    // Any start seen here is dropped; IDLE must be revisited
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_in         = r_idx;
    assign busy           = r_busy;
    assign done           = r_done;
    assign result         = r_result;
    assign pass           = r_pass;
    assign mismatch_count = r_mm;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sweeper
//  Description : Self-checking bench for truth_table_sweeper (two instances,
//                SETTLE_CYCLES = 4 and 1) against a table-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    // Instance A: SETTLE_CYCLES = 4
    logic        start_a = 1'b0;
    logic [15:0] expected_a = '0;
    logic [3:0]  dut_in_a;
    logic        dut_out_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] result_a;
    logic [4:0]  mm_a;
    int          mode_a = 0;
    logic [15:0] tbl_a = '0;

    // Instance B: SETTLE_CYCLES = 1, always driving lab circuit 2
    logic        start_b = 1'b0;
    logic [15:0] expected_b = 16'h70FF;
    logic [3:0]  dut_in_b;
    logic        dut_out_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] result_b;
    logic [4:0]  mm_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Circuit under test: 0 = lab circuit 2, 1 = stuck at 0, else lookup table
    function automatic logic circuit(int mode, logic [3:0] v, logic [15:0] tbl);
        logic a, b, c, d;
        {d, c, b, a} = v;
        if (mode == 0)      return ~(((a & b) | ~c) & d);
        else if (mode == 1) return 1'b0;
        else                return tbl[v];
    endfunction

    // Reference: the full truth table the circuit should produce
    function automatic logic [15:0] model_table(int mode, logic [15:0] tbl);
        logic [15:0] t;
        for (int k = 0; k < 16; k++) t[k] = circuit(mode, 4'(k), tbl);
        return t;
    endfunction

    assign dut_out_a = circuit(mode_a, dut_in_a, tbl_a);
    assign dut_out_b = circuit(0, dut_in_b, 16'h0000);

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .result(result_a), .pass(pass_a), .mismatch_count(mm_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .result(result_b), .pass(pass_b), .mismatch_count(mm_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep on instance A; optional start pulses / expected change
    // mid-sweep that must not disturb the result
    task automatic sweep_a(input string tag, input int mode, input logic [15:0] tbl,
                           input logic [15:0] exp_tbl, input bit disturb);
        int n, busy_n, extra_done;
        logic [15:0] model;
        mode_a = mode; tbl_a = tbl; expected_a = exp_tbl;
        model = model_table(mode, tbl);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        n = 0; busy_n = 0;
        while (n < 200 && !done_a) begin
            if (busy_a) busy_n++;
            if (disturb) begin
                start_a = (n == 10 || n == 40);
                if (n == 20) expected_a = ~exp_tbl;
            end
            @(posedge clk); #1; n++;
        end
        start_a = 1'b0;
        check({tag, ".latency"},  n, 80);
        check({tag, ".busy_cyc"}, busy_n, 80);
        check({tag, ".result"},   result_a, model);
        check({tag, ".mismatch"}, mm_a, $countones(model ^ exp_tbl));
        check({tag, ".pass"},     pass_a, (model == exp_tbl));
        check({tag, ".last_vec"}, dut_in_a, 4'hF);
        extra_done = 0;
        for (int i = 0; i < (disturb ? 60 : 4); i++) begin
            @(posedge clk); #1;
            if (done_a) extra_done++;
        end
        check({tag, ".one_done"},  extra_done, 0);
        check({tag, ".hold_res"},  result_a, model);
        check({tag, ".hold_pass"}, pass_a, (model == exp_tbl));
    endtask

    initial begin
        int n, busy_n, done_n, gap;
        logic [15:0] rt;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.dut_in", dut_in_a, 0);
        check("rst.result", result_a, 0);
        check("rst.mm",     mm_a, 0);
        check("rst.pass",   pass_a, 0);
        check("rst.done",   done_a, 0);
        check("rst.busy",   busy_a, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed tables on lab circuit 2 and a stuck output
        sweep_a("golden",   0, '0, 16'h70FF, 1'b0);
        sweep_a("mismatch", 0, '0, 16'h70FE, 1'b0);
        sweep_a("stuck",    1, '0, 16'h70FF, 1'b0);

        // Start pulses and expected change while busy
        sweep_a("busy_start", 0, '0, 16'h70FF, 1'b1);

        // Randomized circuits, every other one with a matching golden table
        for (int r = 0; r < 6; r++) begin
            rt = 16'($urandom);
            sweep_a("random", 2, rt, (r % 2 == 0) ? rt : 16'($urandom), 1'b0);
        end

        // Timing on instance B: each vector held 2 cycles, busy 32 cycles
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 32; i++) begin
            check("timing.dut_in", dut_in_b, i / 2);
            if (busy_b) busy_n++;
            if (done_b) done_n++;
            @(posedge clk); #1;
        end
        check("timing.busy_cyc",  busy_n, 32);
        check("timing.early_done", done_n, 0);
        check("timing.done",      done_b, 1);
        check("timing.busy_end",  busy_b, 0);
        check("timing.result",    result_b, 16'h70FF);
        check("timing.pass",      pass_b, 1);
        @(posedge clk); #1;
        check("timing.done_pulse", done_b, 0);

        // Asynchronous reset in the middle of a sweep
        mode_a = 0; expected_a = 16'h70FF;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        n = 0;
        while (n < 200 && dut_in_a != 4'd7) begin
            @(posedge clk); #1; n++;
        end
        check("arst.reach7", dut_in_a, 7);
        #2 rst_n = 1'b0;
        #1;
        check("arst.dut_in", dut_in_a, 0);
        check("arst.result", result_a, 0);
        check("arst.busy",   busy_a, 0);
        check("arst.done",   done_a, 0);
        @(negedge clk); rst_n = 1'b1;
        done_n = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done_a) done_n++;
        end
        check("arst.no_done", done_n, 0);
        sweep_a("after_rst", 0, '0, 16'h70FF, 1'b0);

        // start held high: back-to-back sweeps with one IDLE cycle between
        mode_a = 0; expected_a = 16'h70FF;
        @(negedge clk); start_a = 1'b1;
        n = 0;
        while (n < 200 && !done_a) begin
            @(posedge clk); #1; n++;
        end
        gap = 0;
        do begin
            @(posedge clk); #1; gap++;
        end while (gap < 200 && !done_a);
        start_a = 1'b0;
        check("b2b.gap",  gap, 82);
        check("b2b.pass", pass_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_truth_table_sweeper
`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream of a small combinational lab circuit (up to N_IN inputs, 1 output). It drives that circuit and records its response.
- On a start pulse it steps a binary counter through all 2**N_IN input vectors. For each vector it waits a programmable settle time, then samples the circuit output.
- It builds the measured truth table and compares it against an expected table. It reports done, pass and a mismatch count.
- This replaces delay-based software sweeps with a clocked, synthesizable sweep.

Parameters:
- N_IN, 4, number of circuit inputs; table width is 2**N_IN.
- SETTLE_CYCLES, 4, clock cycles each vector is held before sampling; legal range 1..255; 0 is illegal.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; sampled only in IDLE.
- expected  input  2**N_IN  golden truth table; bit k = expected output for vector k; latched at start.
- dut_in  output  N_IN  vector applied to circuit; bit0 = inA, bit1 = inB, bit2 = inC, bit3 = inD.
- dut_out  input  1  circuit output, same clock domain, combinational.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse at end of sweep.
- result  output  2**N_IN  measured table; bit k = dut_out sampled for vector k.
- pass  output  1  result == latched expected; valid from done, held until next start.
- mismatch_count  output  N_IN+1  number of differing bits.

Behaviour:
- Reset (async assert, sync release): state = IDLE. dut_in, result, mismatch_count, pass, done, busy and the latched expected are all 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 at an edge moves to SETTLE.
  - That edge also sets dut_in = 0, idx = 0, settle_cnt = SETTLE_CYCLES-1, exp_q = expected, and clears result, mismatch_count and pass.
- SETTLE:
  - settle_cnt decrements each cycle.
  - When settle_cnt == 0, the next state is SAMPLE.
- SAMPLE (one cycle):
  - At the exiting edge: result[idx] <= dut_out, and mismatch_count increments if dut_out != exp_q[idx].
  - If idx == 2**N_IN-1, go to DONE.
  - Otherwise idx++, dut_in <= idx+1, settle_cnt reloads, and the next state is SETTLE.
- DONE (one cycle):
  - done = 1 and busy = 0.
  - pass = (final mismatch_count == 0), registered on entry to DONE.
  - Next state is IDLE.
- Timing, with start accepted at edge E0:
  - Vector k is held for exactly SETTLE_CYCLES+1 cycles.
  - Vector k is sampled at edge E0 + (k+1)(SETTLE_CYCLES+1).
  - DONE is entered at edge E0 + 2**N_IN*(SETTLE_CYCLES+1).
- dut_in changes only on edges leaving SAMPLE (or on the start edge), never mid-settle.
- After DONE:
  - dut_in holds the last vector.
  - result, mismatch_count and pass hold until the next accepted start.
- start while busy or in DONE is ignored. No queuing; a pulse landing in DONE is lost.
- start held high continuously: back-to-back sweeps, one IDLE cycle between them.
- expected changing mid-sweep has no effect, because exp_q is used.
- Reset mid-sweep: immediate return to the reset values; no done pulse.
- mismatch_count maximum is 2**N_IN, which fits N_IN+1 bits; no saturation logic.

Decomposition:
- Shared package:
  - state enum (IDLE, SETTLE, SAMPLE, DONE).
  - default constants N_IN_DEF = 4 and SETTLE_DEF = 4.
  - the lab-circuit-2 golden constant 16'h70FF.
- One natural sub-module: sweep_settle_timer.
  - Load/decrement counter, width 8.
  - Ports: clk, rst_n, load, zero.
  - Instantiated once.
- Index counter, compare and FSM stay in the top module.

Test Plan:
- Golden match:
  - Stimulus: lab circuit 2 (out = ~(((inA&inB)|~inC)&inD)) connected, expected = 16'h70FF, SETTLE_CYCLES = 4, single start pulse.
  - Response: done exactly 80 cycles after the start edge; result = 16'h70FF; mismatch_count = 0; pass = 1.
- Mismatch count:
  - Stimulus: same circuit, expected = 16'h70FE.
  - Response: result = 16'h70FF; mismatch_count = 1; pass = 0.
- Stuck output:
  - Stimulus: dut_out tied to 0, expected = 16'h70FF.
  - Response: result = 0; mismatch_count = 11; pass = 0.
- Timing:
  - Stimulus: SETTLE_CYCLES = 1, monitor dut_in.
  - Response: dut_in steps 0..15, each value held exactly 2 cycles; busy high for exactly 32 cycles; done high for exactly 1 cycle.
- Reset mid-sweep:
  - Stimulus: assert rst_n = 0 asynchronously while dut_in = 7.
  - Response: dut_in, result and busy go to 0 immediately with no clock edge; no done pulse; a new start then completes a normal sweep.
- Start while busy:
  - Stimulus: pulse start at cycles 10 and 40, and change expected at cycle 20.
  - Response: one sweep only; it compares against the table latched at cycle 0; done occurs once.
